ps2_led_ctrl: RTL

- Host-to-device command sequencer for the PS/2 keyboard port.
- On request, it sends the two-byte "set LEDs" command (0xED, then the LED byte) by driving the open-drain PS/2 clock and data lines.
- It waits for the keyboard's 0xFA acknowledge on the receive path (ps2_decoder byte stream), and handles resend, timeout and retry.
- It sits beside ps2_decoder and owns the line drivers; the decoder keeps its receive-only role.

---
 rtl/ps2_led_ctrl_pkg.sv | 28 ++
 rtl/ps2_led_ctrl_if.sv | 15 +
 rtl/ps2_led_ctrl_tx_frame.sv | 126 ++++++++++++
 rtl/ps2_led_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ps2_led_ctrl_pkg.sv
// Shared constants and state encodings for the PS/2 host-to-device LED command path.
package ps2_pkg;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_ACK         = 8'hFA;
    localparam logic [7:0] PS2_RESEND      = 8'hFE;

    // Bit-level frame states (owned by ps2_tx_frame)
    typedef enum logic [2:0] {
        F_IDLE,
        F_INHIBIT,
        F_RELEASE,
        F_TX_BITS,
        F_TX_ACK
    } frame_state_t;

    // Command sequencing states (owned by ps2_led_ctrl)
    typedef enum logic [1:0] {
        C_IDLE,
        C_SEND,
        C_REPLY
    } ctrl_state_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_led_ctrl_if.sv
// Request/reply bundle between the LED command sequencer and its host logic.
interface ps2_led_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       led_req;
    logic [2:0] led_val;
    logic       busy;
    logic       done;
    logic       err;

    modport slave  (input  rx_valid, rx_byte, led_req, led_val,
                    output busy, done, err);
    modport master (output rx_valid, rx_byte, led_req, led_val,
                    input  busy, done, err);
endinterface

// File: rtl/ps2_led_ctrl_tx_frame.sv
// Sends one host-to-device PS/2 frame: clock inhibit, start bit, 8 data bits,
// odd parity, stop, then samples the device line-level ack.
module ps2_tx_frame
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REPLY_TIMEOUT  = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    input  logic       i_fall,
    input  logic       i_data,
    output logic       o_line_ack,
    output logic       o_line_nak,
    output logic       o_timeout,
    output logic       o_clk_oe,
    output logic       o_data_oe
);
    localparam int CMAX = (INHIBIT_CYCLES > REPLY_TIMEOUT) ? INHIBIT_CYCLES : REPLY_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    frame_state_t  r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [8:0]    r_shift;
    logic [3:0]    r_bit_cnt;
    logic          r_data_oe, w_data_oe_nxt;
    logic          r_ack, r_nak, r_to;
    logic          w_ack, w_nak, w_to, w_shift_en, w_tx_fall;
    logic          w_hit_inh, w_hit_to;

    assign w_hit_inh = (r_cnt == CW'(INHIBIT_CYCLES - 1));
    assign w_hit_to  = (r_cnt == CW'(REPLY_TIMEOUT - 1));
    // Our own inhibit also produces a falling edge; only device edges while transmitting count.
    assign w_tx_fall = i_fall && (r_state == F_TX_BITS || r_state == F_TX_ACK);

    always_comb begin
        w_state_nxt   = r_state;
        w_data_oe_nxt = r_data_oe;
        w_ack         = 1'b0;
        w_nak         = 1'b0;
        w_to          = 1'b0;
        w_shift_en    = 1'b0;
        case (r_state)
            F_IDLE: begin
                w_data_oe_nxt = 1'b0;
                if (i_start) w_state_nxt = F_INHIBIT;
            end
            F_INHIBIT: begin
                if (w_hit_inh) begin
                    w_data_oe_nxt = 1'b1;
                    w_state_nxt   = F_RELEASE;
                end
            end
            F_RELEASE: w_state_nxt = F_TX_BITS;
            F_TX_BITS: begin
                if (w_tx_fall) begin
                    if (r_bit_cnt == 4'd9) begin
                        w_data_oe_nxt = 1'b0;
                        w_state_nxt   = F_TX_ACK;
                    end else begin
                        w_data_oe_nxt = ~r_shift[0];
                        w_shift_en    = 1'b1;
                    end
                end else if (w_hit_to) begin
                    w_to          = 1'b1;
                    w_data_oe_nxt = 1'b0;
                    w_state_nxt   = F_IDLE;
                end
            end
            F_TX_ACK: begin
                w_data_oe_nxt = 1'b0;
                if (w_tx_fall) begin
                    w_ack       = ~i_data;
                    w_nak       = i_data;
                    w_state_nxt = F_IDLE;
                end else if (w_hit_to) begin
                    w_to        = 1'b1;
                    w_state_nxt = F_IDLE;
                end
            end
            default: begin
                w_data_oe_nxt = 1'b0;
                w_state_nxt   = F_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= F_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_data_oe <= 1'b0;
            r_ack     <= 1'b0;
            r_nak     <= 1'b0;
            r_to      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_data_oe <= w_data_oe_nxt;
            r_ack     <= w_ack;
            r_nak     <= w_nak;
            r_to      <= w_to;
            if (w_state_nxt != r_state || w_tx_fall)
                r_cnt <= '0;
            else if (r_state != F_IDLE)
                r_cnt <= r_cnt + 1'b1;
            if (r_state == F_IDLE && i_start) begin
                r_shift   <= {odd_parity(i_byte), i_byte};
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_shift   <= {1'b0, r_shift[8:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    assign o_clk_oe   = (r_state == F_INHIBIT);
    assign o_data_oe  = r_data_oe;
    assign o_line_ack = r_ack;
    assign o_line_nak = r_nak;
    assign o_timeout  = r_to;

endmodule

// File: rtl/ps2_led_ctrl.sv
// PS/2 "set LEDs" sequencer: sends 0xED then the LED byte, waits for 0xFA after
// each, retries on resend/timeout/missing line ack, and queues one pending request.
module ps2_led_ctrl
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REPLY_TIMEOUT  = 1000000,
    parameter int MAX_RETRY      = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_async,
    input  logic ps2_data_async,
    output logic ps2_clk_oe,
    output logic ps2_data_oe,
    ps2_led_ctrl_if.slave ctl
);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int TW = $clog2(REPLY_TIMEOUT + 1);

    logic r_clk_s1, r_clk_s2, r_clk_prev, r_data_s1, r_data_s2;
    logic w_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_data_s1  <= 1'b1;
            r_data_s2  <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk_async;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_data_s1  <= ps2_data_async;
            r_data_s2  <= r_data_s1;
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_s2;

    ctrl_state_t   r_state, w_state_nxt;
    logic          r_idx, w_idx_nxt;
    logic [RW-1:0] r_retry, w_retry_nxt;
    logic [2:0]    r_led, w_led_nxt;
    logic          r_pend, w_pend_nxt;
    logic [2:0]    r_pend_val, w_pend_val_nxt;
    logic          r_busy, w_busy_nxt, r_done, w_done_nxt, r_err, w_err_nxt;
    logic [TW-1:0] r_to_cnt;
    logic          w_start, w_retry_path, w_reply_to;
    logic [7:0]    w_tx_byte;
    logic          w_line_ack, w_line_nak, w_tx_to;

    assign w_reply_to = (r_state == C_REPLY) && (r_to_cnt == TW'(REPLY_TIMEOUT - 1));
    // Byte 0 is always the command; the LED value is already latched when byte 1 starts.
    assign w_tx_byte  = w_idx_nxt ? {5'b0, r_led} : PS2_CMD_SET_LED;

    ps2_tx_frame #(
        .INHIBIT_CYCLES (INHIBIT_CYCLES),
        .REPLY_TIMEOUT  (REPLY_TIMEOUT)
    ) u_frame (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_byte     (w_tx_byte),
        .i_fall     (w_fall),
        .i_data     (r_data_s2),
        .o_line_ack (w_line_ack),
        .o_line_nak (w_line_nak),
        .o_timeout  (w_tx_to),
        .o_clk_oe   (ps2_clk_oe),
        .o_data_oe  (ps2_data_oe)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_retry_nxt    = r_retry;
        w_led_nxt      = r_led;
        w_pend_nxt     = r_pend;
        w_pend_val_nxt = r_pend_val;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_start        = 1'b0;
        w_retry_path   = 1'b0;
        case (r_state)
            C_IDLE: begin
                if (ctl.led_req || r_pend) begin
                    w_led_nxt   = ctl.led_req ? ctl.led_val : r_pend_val;
                    w_pend_nxt  = 1'b0;
                    w_idx_nxt   = 1'b0;
                    w_retry_nxt = '0;
                    w_busy_nxt  = 1'b1;
                    w_start     = 1'b1;
                    w_state_nxt = C_SEND;
                end
            end
            C_SEND: begin
                if (w_line_ack)
                    w_state_nxt = C_REPLY;
                else if (w_line_nak || w_tx_to)
                    w_retry_path = 1'b1;
            end
            C_REPLY: begin
                if (ctl.rx_valid) begin
                    if (ctl.rx_byte == PS2_ACK) begin
                        if (!r_idx) begin
                            w_idx_nxt   = 1'b1;
                            w_retry_nxt = '0;
                            w_start     = 1'b1;
                            w_state_nxt = C_SEND;
                        end else begin
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = C_IDLE;
                        end
                    end else if (ctl.rx_byte == PS2_RESEND) begin
                        w_retry_path = 1'b1;
                    end
                end else if (w_reply_to) begin
                    w_retry_path = 1'b1;
                end
            end
            default: w_state_nxt = C_IDLE;
        endcase
        if (w_retry_path) begin
            if (r_retry < RW'(MAX_RETRY)) begin
                w_retry_nxt = r_retry + 1'b1;
                w_start     = 1'b1;
                w_state_nxt = C_SEND;
            end else begin
                w_err_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = C_IDLE;
            end
        end
        // A request arriving outside IDLE (including on the done/err cycle) waits its turn.
        if (ctl.led_req && r_state != C_IDLE) begin
            w_pend_nxt     = 1'b1;
            w_pend_val_nxt = ctl.led_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= C_IDLE;
            r_idx      <= 1'b0;
            r_retry    <= '0;
            r_led      <= '0;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_to_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_retry    <= w_retry_nxt;
            r_led      <= w_led_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_val <= w_pend_val_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            if (w_state_nxt != r_state || w_fall)
                r_to_cnt <= '0;
            else if (r_state == C_REPLY)
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign ctl.busy = r_busy;
    assign ctl.done = r_done;
    assign ctl.err  = r_err;

endmodule
